// File: rtl/puf_readout_ctrl.sv
// PUF readout sequencer: excite the array, let it settle, sweep every address,
// and stream each response word followed by an XOR checksum word.
//
// Ports:
//   clk         clock
//   reset       asynchronous, active-high
//   go          run request, sampled only while idle
//   puf_start   PUF excitation strobe
//   puf_addr    PUF word address
//   puf_data    PUF response word, valid one cycle after puf_addr
//   data_out    streamed response word or checksum
//   data_valid  data_out holds a word for the sink
//   data_ready  sink accepts the word when data_valid && data_ready
//   data_last   marks the checksum word
//   busy        high while a run is in progress
//   done        one-cycle pulse once the checksum has been accepted
module puf_readout_ctrl #(
    parameter int ADDR_BITS     = 4,
    parameter int OUT_BITS      = 8,
    parameter int EXCITE_CYCLES = 8,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    output logic                 puf_start,
    output logic [ADDR_BITS-1:0] puf_addr,
    input  logic [OUT_BITS-1:0]  puf_data,
    output logic [OUT_BITS-1:0]  data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 data_last,
    output logic                 busy,
    output logic                 done
);

    localparam int MAXC = (EXCITE_CYCLES > SETTLE_CYCLES) ?
                          EXCITE_CYCLES : SETTLE_CYCLES;
    localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0]        EX_LAST  = CW'(EXCITE_CYCLES - 1);
    localparam logic [CW-1:0]        ST_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]        FE_LAST  = CW'(1);
    localparam logic [ADDR_BITS-1:0] LAST_IDX = '1;

    typedef enum logic [2:0] {
        IDLE,
        EXCITE,
        SETTLE,
        FETCH,
        SEND,
        CSUM
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [ADDR_BITS-1:0]  idx;
    logic [OUT_BITS-1:0]   csum;

    // The address register is the sweep index itself.
    assign puf_addr = idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            csum       <= '0;
            puf_start  <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            data_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        state     <= EXCITE;
                        busy      <= 1'b1;
                        puf_start <= 1'b1;
                        cnt       <= '0;
                        idx       <= '0;
                        csum      <= '0;
                    end
                end
                EXCITE: begin
                    if (cnt == EX_LAST) begin
                        state     <= SETTLE;
                        puf_start <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SETTLE: begin
                    if (cnt == ST_LAST) begin
                        state <= FETCH;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FETCH: begin
                    // Second cycle: the PUF output register now holds word[idx].
                    if (cnt == FE_LAST) begin
                        state      <= SEND;
                        cnt        <= '0;
                        data_out   <= puf_data;
                        csum       <= csum ^ puf_data;
                        data_valid <= 1'b1;
                        data_last  <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SEND: begin
                    if (data_ready) begin
                        if (idx == LAST_IDX) begin
                            // Checksum follows immediately; valid stays high.
                            state     <= CSUM;
                            data_out  <= csum;
                            data_last <= 1'b1;
                        end else begin
                            state      <= FETCH;
                            data_valid <= 1'b0;
                            idx        <= idx + ADDR_BITS'(1);
                        end
                    end
                end
                CSUM: begin
                    if (data_ready) begin
                        state      <= IDLE;
                        data_valid <= 1'b0;
                        data_last  <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_readout_ctrl.sv
// Bench for puf_readout_ctrl: run-level model with per-cycle compare,
// directed scenarios and randomized sink back-pressure.
module tb_puf_readout_ctrl;

    localparam int AB = 2;
    localparam int OB = 8;
    localparam int EX = 2;
    localparam int ST = 3;
    localparam int N  = 1 << AB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          go = 1'b0;
    logic          data_ready = 1'b0;
    logic          puf_start;
    logic [AB-1:0] puf_addr;
    logic [OB-1:0] puf_data = '0;
    logic [OB-1:0] data_out;
    logic          data_valid;
    logic          data_last;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    puf_readout_ctrl #(
        .ADDR_BITS    (AB),
        .OUT_BITS     (OB),
        .EXCITE_CYCLES(EX),
        .SETTLE_CYCLES(ST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .puf_start (puf_start),
        .puf_addr  (puf_addr),
        .puf_data  (puf_data),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .data_last (data_last),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [7:0] word(int a);
        return 8'(17 * (a + 1));
    endfunction

    function automatic logic [7:0] csum_all();
        logic [7:0] x = '0;
        for (int i = 0; i < N; i++) x ^= word(i);
        return x;
    endfunction

    // PUF array: registered output, one cycle behind the address.
    always @(posedge clk) puf_data <= word(int'(puf_addr));

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run-level model state, advanced once per cycle.
    bit         mbusy = 0;
    bit         mdone = 0;
    int         age   = 0;
    int         mwait = 0;
    int         pos   = 0;
    bit         stall = 0;
    logic [7:0] pv_data;
    logic       pv_last;
    bit         vexp;

    // Observations for the directed checks and per-run scoreboard.
    int         done_cnt = 0;
    logic [7:0] rx_words[$];
    bit         rx_last[$];
    int         run_n = 0;
    logic [7:0] run_x = '0;

    always @(negedge clk) begin
        if (reset) begin
            check("rst_outs",
                  {puf_start, puf_addr, data_out, data_valid,
                   data_last, busy, done}, 0);
            mbusy = 0;
            mdone = 0;
            pos   = 0;
            mwait = 0;
            age   = 0;
            stall = 0;
            run_n = 0;
            run_x = '0;
        end else begin
            vexp = mbusy && (mwait == 0);
            check("busy", busy, mbusy);
            check("done", done, mdone);
            check("start", puf_start, mbusy && (age < EX));
            check("valid", data_valid, vexp);
            check("last", data_last, vexp && (pos == N));
            if (mbusy)
                check("addr", puf_addr, (pos < N) ? pos : N - 1);
            if (vexp)
                check("data", data_out, (pos < N) ? word(pos) : csum_all());
            if (stall) begin
                check("hold_data", data_out, pv_data);
                check("hold_last", data_last, pv_last);
            end
            stall   = data_valid && !data_ready;
            pv_data = data_out;
            pv_last = data_last;

            if (done) done_cnt++;
            if (data_valid && data_ready) begin
                rx_words.push_back(data_out);
                rx_last.push_back(data_last);
                if (data_last) begin
                    check("run_len", run_n, N);
                    check("run_csum", data_out, run_x);
                    run_n = 0;
                    run_x = '0;
                end else begin
                    run_n++;
                    run_x ^= data_out;
                end
            end

            mdone = 0;
            if (!mbusy) begin
                if (go) begin
                    mbusy = 1;
                    age   = 0;
                    pos   = 0;
                    mwait = EX + ST + 2;
                end
            end else begin
                age++;
                if (mwait > 0) begin
                    mwait--;
                end else if (data_ready) begin
                    if (pos == N) begin
                        mbusy = 0;
                        mdone = 1;
                    end else begin
                        pos++;
                        mwait = (pos == N) ? 0 : 2;
                    end
                end
            end
        end
    end

    task automatic wait_valid(string nm);
        int n = 0;
        while (!data_valid && n < 200) begin
            tick();
            n++;
        end
        check({nm, "_valid_to"}, data_valid, 1);
    endtask

    task automatic wait_done(string nm);
        int n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        check({nm, "_done_to"}, done, 1);
    endtask

    logic [7:0] exp1[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};

    initial begin
        int base, d0, k, krise, klow, kval, nhi, lowc, dseen;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        check("rst_valid", data_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_start", puf_start, 0);
        reset = 1'b0;
        tick();

        // 1: single run, ready held high
        data_ready = 1'b1;
        base = rx_words.size();
        d0   = done_cnt;
        go   = 1'b1;
        tick();
        go    = 1'b0;
        k     = 1;
        krise = -1;
        klow  = -1;
        kval  = -1;
        nhi   = 0;
        while (k < 200 && !done) begin
            if (puf_start) begin
                nhi++;
                if (krise < 0) krise = k;
            end else if (krise >= 0 && klow < 0) begin
                klow = k;
            end
            if (data_valid && kval < 0) kval = k;
            tick();
            k++;
        end
        check("t1_done_to", done, 1);
        check("t1_busy_in_done", busy, 0);
        tick();
        check("t1_done_once", done_cnt - d0, 1);
        check("t1_done_low", done, 0);
        check("t1_start_len", nhi, 2);
        check("t1_start_fall", klow - krise, 2);
        check("t1_first_valid", kval - krise, 7);
        check("t1_nwords", rx_words.size() - base, 5);
        for (int i = 0; i < 5; i++) begin
            check("t1_word", rx_words[base + i], exp1[i]);
            check("t1_lastflag", rx_last[base + i], i == 4);
        end

        // 2: ten-cycle stall on word 2
        data_ready = 1'b0;
        base = rx_words.size();
        go   = 1'b1;
        tick();
        go = 1'b0;
        wait_valid("t2a");
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        wait_valid("t2b");
        for (int i = 0; i < 10; i++) begin
            check("t2_stall_data", data_out, 8'h22);
            check("t2_stall_valid", data_valid, 1);
            tick();
        end
        data_ready = 1'b1;
        wait_done("t2");
        tick();
        check("t2_nwords", rx_words.size() - base, 5);
        check("t2_csum", rx_words[base + 4], 8'h44);

        // 3: go during SEND of word 1 is ignored
        data_ready = 1'b0;
        base = rx_words.size();
        d0   = done_cnt;
        go   = 1'b1;
        tick();
        go = 1'b0;
        wait_valid("t3");
        go = 1'b1;
        repeat (3) tick();
        go = 1'b0;
        data_ready = 1'b1;
        wait_done("t3");
        repeat (20) tick();
        check("t3_nwords", rx_words.size() - base, 5);
        check("t3_done_once", done_cnt - d0, 1);
        check("t3_idle", busy, 0);

        // 4: reset during SEND of word 2
        data_ready = 1'b0;
        d0 = done_cnt;
        go = 1'b1;
        tick();
        go = 1'b0;
        wait_valid("t4a");
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        wait_valid("t4b");
        reset = 1'b1;
        #1;
        check("t4_rst_valid", data_valid, 0);
        check("t4_rst_data", data_out, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_addr", puf_addr, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("t4_no_done", done_cnt - d0, 0);
        base = rx_words.size();
        data_ready = 1'b1;
        go = 1'b1;
        tick();
        go = 1'b0;
        wait_done("t4");
        tick();
        check("t4_nwords", rx_words.size() - base, 5);
        check("t4_csum", rx_words[base + 4], 8'h44);

        // 5: go tied high, back-to-back runs
        base  = rx_words.size();
        lowc  = 0;
        dseen = 0;
        go    = 1'b1;
        k     = 0;
        while (dseen < 3 && k < 300) begin
            tick();
            k++;
            if (!busy) lowc++;
            if (done) dseen++;
        end
        go = 1'b0;
        check("t5_runs", dseen, 3);
        check("t5_busy_low", lowc, 3);
        tick();
        check("t5_stays_idle", busy, 0);
        check("t5_nwords", rx_words.size() - base, 15);

        // 6: random back-pressure over 50 runs
        base = rx_words.size();
        d0   = done_cnt;
        for (int r = 0; r < 50; r++) begin
            go = 1'b1;
            tick();
            go = 1'b0;
            k = 0;
            while (!done && k < 1000) begin
                data_ready = 1'($urandom_range(0, 1));
                tick();
                k++;
            end
            check("t6_done_to", done, 1);
        end
        tick();
        check("t6_runs", done_cnt - d0, 50);
        check("t6_nwords", rx_words.size() - base, 250);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
